// File: rtl/regfile_scoreboard.sv
// Register file with two combinational read ports, one write port and a
// per-entry pending scoreboard. Entry 0 reads zero and is never pending.
// Optional feature macro: REGFILE_BYPASS_EN forwards a same-cycle writeback
// to both read ports (data and busy).
module regfile_scoreboard #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned CNT_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [ADDR_WIDTH-1:0] i_rs1_addr,
  input  logic [ADDR_WIDTH-1:0] i_rs2_addr,
  output logic [DATA_WIDTH-1:0] o_rs1_data,
  output logic [DATA_WIDTH-1:0] o_rs2_data,
  output logic                  o_rs1_busy,
  output logic                  o_rs2_busy,
  input  logic                  i_issue_valid,
  input  logic [ADDR_WIDTH-1:0] i_issue_rd,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  input  logic [DATA_WIDTH-1:0] i_rd_data,
  input  logic                  i_rd_wren,
  output logic [CNT_WIDTH-1:0]  o_busy_cnt,
  output logic                  o_wb_err
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [Depth];
  logic [Depth-1:0]      pend_q, pend_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  wb_err_q, wb_err_d;

  logic wr_en, set_en, same_rd, inc, dec;

  // Address 0 is inert for both writeback and issue.
  assign wr_en   = i_rd_wren && (i_rd_addr != '0);
  assign set_en  = i_issue_valid && (i_issue_rd != '0);
  assign same_rd = set_en && (i_issue_rd == i_rd_addr);

  // Next-state for pending bits, occupancy counter and sticky error.
  always_comb begin
    pend_d = pend_q;
    if (wr_en) pend_d[i_rd_addr] = 1'b0;
    // Set after clear: a new producer overrides the retiring one.
    if (set_en) pend_d[i_issue_rd] = 1'b1;
    pend_d[0] = 1'b0;

    inc = set_en && !pend_q[i_issue_rd];
    dec = wr_en && pend_q[i_rd_addr] && !same_rd;

    cnt_d = cnt_q;
    if (inc && !dec) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end else if (dec && !inc) begin
      cnt_d = cnt_q - CNT_WIDTH'(1);
    end

    wb_err_d = wb_err_q | (wr_en && !pend_q[i_rd_addr]);
  end

  // Data storage; entry 0 is only ever reset, so it stays zero.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[i_rd_addr] <= i_rd_data;
    end
  end

  // Scoreboard state, pending count and sticky writeback error.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      pend_q   <= '0;
      cnt_q    <= '0;
      wb_err_q <= 1'b0;
    end else begin
      pend_q   <= pend_d;
      cnt_q    <= cnt_d;
      wb_err_q <= wb_err_d;
    end
  end

  assign o_busy_cnt = cnt_q;
  assign o_wb_err   = wb_err_q;

  // Combinational read ports with optional writeback forwarding.
  always_comb begin
    o_rs1_data = mem_q[i_rs1_addr];
    o_rs1_busy = pend_q[i_rs1_addr];
    o_rs2_data = mem_q[i_rs2_addr];
    o_rs2_busy = pend_q[i_rs2_addr];
`ifdef REGFILE_BYPASS_EN
    // Gated by reset so outputs stay zero while reset is held.
    if (i_reset && wr_en && (i_rs1_addr == i_rd_addr)) begin
      o_rs1_data = i_rd_data;
      o_rs1_busy = same_rd;
    end
    if (i_reset && wr_en && (i_rs2_addr == i_rd_addr)) begin
      o_rs2_data = i_rd_data;
      o_rs2_busy = same_rd;
    end
`endif
    if (i_rs1_addr == '0) begin
      o_rs1_data = '0;
      o_rs1_busy = 1'b0;
    end
    if (i_rs2_addr == '0) begin
      o_rs2_data = '0;
      o_rs2_busy = 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: directed plan steps followed by
// random traffic, all compared against an array/bit-vector reference model.
module tb_regfile_scoreboard;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = AW + 1;
  localparam int N  = 2 ** AW;

  logic          i_clk = 1'b0;
  logic          i_reset;
  logic [AW-1:0] i_rs1_addr, i_rs2_addr, i_issue_rd, i_rd_addr;
  logic [DW-1:0] o_rs1_data, o_rs2_data, i_rd_data;
  logic          o_rs1_busy, o_rs2_busy, i_issue_valid, i_rd_wren, o_wb_err;
  logic [CW-1:0] o_busy_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [DW-1:0] mem_m [N];
  logic [N-1:0]  pend_m;
  logic          err_m;

  regfile_scoreboard #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .CNT_WIDTH (CW)
  ) dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_rs1_addr   (i_rs1_addr),
    .i_rs2_addr   (i_rs2_addr),
    .o_rs1_data   (o_rs1_data),
    .o_rs2_data   (o_rs2_data),
    .o_rs1_busy   (o_rs1_busy),
    .o_rs2_busy   (o_rs2_busy),
    .i_issue_valid(i_issue_valid),
    .i_issue_rd   (i_issue_rd),
    .i_rd_addr    (i_rd_addr),
    .i_rd_data    (i_rd_data),
    .i_rd_wren    (i_rd_wren),
    .o_busy_cnt   (o_busy_cnt),
    .o_wb_err     (o_wb_err)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic forwarding(input logic [AW-1:0] a);
`ifdef REGFILE_BYPASS_EN
    return i_rd_wren && (i_rd_addr != 0) && (a == i_rd_addr);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] a);
    if (!i_reset || a == 0) return '0;
    if (forwarding(a)) return i_rd_data;
    return mem_m[a];
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] a);
    if (!i_reset || a == 0) return 1'b0;
    if (forwarding(a)) return i_issue_valid && (i_issue_rd == a);
    return pend_m[a];
  endfunction

  task automatic check_outputs();
    check("rs1_data", 64'(o_rs1_data), 64'(exp_data(i_rs1_addr)));
    check("rs2_data", 64'(o_rs2_data), 64'(exp_data(i_rs2_addr)));
    check("rs1_busy", 64'(o_rs1_busy), 64'(exp_busy(i_rs1_addr)));
    check("rs2_busy", 64'(o_rs2_busy), 64'(exp_busy(i_rs2_addr)));
    check("busy_cnt", 64'(o_busy_cnt), 64'($countones(pend_m)));
    check("wb_err", 64'(o_wb_err), 64'(err_m));
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) mem_m[i] = '0;
    pend_m = '0;
    err_m  = 1'b0;
  endtask

  // Apply one clock edge's worth of architectural effect.
  task automatic model_update();
    if (i_rd_wren && i_rd_addr != 0) begin
      if (!pend_m[i_rd_addr]) err_m = 1'b1;
      mem_m[i_rd_addr]  = i_rd_data;
      pend_m[i_rd_addr] = 1'b0;
    end
    if (i_issue_valid && i_issue_rd != 0) pend_m[i_issue_rd] = 1'b1;
  endtask

  task automatic idle(input logic [AW-1:0] r1, input logic [AW-1:0] r2);
    i_rs1_addr    = r1;
    i_rs2_addr    = r2;
    i_issue_valid = 1'b0;
    i_issue_rd    = '0;
    i_rd_wren     = 1'b0;
    i_rd_addr     = '0;
    i_rd_data     = '0;
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic cycle();
    #1 check_outputs();
    @(posedge i_clk);
    if (i_reset) model_update();
    @(negedge i_clk);
  endtask

  initial begin
    i_reset = 1'b0;
    idle('0, '0);
    model_reset();
    #2;
    // All addresses read zero while reset is held.
    for (int a = 0; a < N; a++) begin
      i_rs1_addr = AW'(a);
      i_rs2_addr = AW'(N - 1 - a);
      #1 check_outputs();
    end
    @(negedge i_clk);
    i_reset = 1'b1;
    idle('0, '0);
    cycle();

    // Issue 5, then write it back.
    idle(5, 0); i_issue_valid = 1; i_issue_rd = 5; cycle();
    idle(5, 5); cycle();
    idle(5, 0); i_rd_wren = 1; i_rd_addr = 5; i_rd_data = 32'hDEADBEEF; cycle();
    idle(5, 5); cycle();
    check("plan_wb_data", 64'(o_rs1_data), 64'h0000_0000_DEAD_BEEF);

    // Same-cycle read of the writeback address.
    idle(7, 7); i_issue_valid = 1; i_issue_rd = 7; cycle();
    idle(7, 7); i_rd_wren = 1; i_rd_addr = 7; i_rd_data = 32'h12345678; cycle();
    idle(7, 7); cycle();

    // Simultaneous set and clear of entry 9.
    idle(9, 0); i_issue_valid = 1; i_issue_rd = 9; cycle();
    idle(9, 9); i_issue_valid = 1; i_issue_rd = 9;
    i_rd_wren = 1; i_rd_addr = 9; i_rd_data = 32'hA5A5_0009; cycle();
    idle(9, 9); cycle();

    // Entry 0 ignores writes and issues and raises no error.
    idle(0, 0); i_issue_valid = 1; i_issue_rd = 0;
    i_rd_wren = 1; i_rd_addr = 0; i_rd_data = 32'hFFFFFFFF; cycle();
    idle(0, 0); cycle();

    // Writeback to a non-pending entry sets the sticky error.
    idle(3, 0); i_rd_wren = 1; i_rd_addr = 3; i_rd_data = 32'h0000_0033; cycle();
    idle(3, 0); cycle();
    idle(0, 3); cycle();
    check("err_sticky", 64'(o_wb_err), 64'd1);

    // Random traffic concentrated on a few entries to create hazards.
    for (int k = 0; k < 400; k++) begin
      i_rs1_addr    = AW'($urandom_range(0, 7));
      i_rs2_addr    = ($urandom_range(0, 3) == 0) ? i_rs1_addr : AW'($urandom_range(0, 7));
      i_issue_valid = 1'($urandom_range(0, 1));
      i_issue_rd    = AW'($urandom_range(0, 7));
      i_rd_wren     = 1'($urandom_range(0, 1));
      i_rd_addr     = ($urandom_range(0, 2) == 0) ? i_rs1_addr : AW'($urandom_range(0, 7));
      i_rd_data     = $urandom;
      cycle();
    end

    // Fill the scoreboard, then reset asynchronously between edges.
    for (int a = 1; a < N; a++) begin
      idle(AW'(a), '0); i_issue_valid = 1; i_issue_rd = AW'(a); cycle();
    end
    idle(31, 1); cycle();
    check("cnt_full", 64'(o_busy_cnt), 64'd31);
    idle(31, 1); i_rd_wren = 1; i_rd_addr = 31; i_rd_data = 32'h5555AAAA;
    i_issue_valid = 1; i_issue_rd = 2;
    #2 i_reset = 1'b0;
    model_reset();
    #1 check_outputs();
    @(posedge i_clk);
    #1 check_outputs();
    @(negedge i_clk);
    i_reset = 1'b1;
    idle(31, 2); cycle();

    // Normal operation resumes after reset.
    idle(4, 4); i_issue_valid = 1; i_issue_rd = 4; cycle();
    idle(4, 0); i_rd_wren = 1; i_rd_addr = 4; i_rd_data = 32'hCAFE0004; cycle();
    idle(4, 4); cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
